// File: rtl/fifo_pixel_unpacker.sv
// Unpacks 32-bit packed FIFO words (3 words -> 4 RGB888 pixels, MSB-first)
// into a ready/valid pixel stream, tracking line and frame position.
module fifo_pixel_unpacker #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480
) (
  input  logic        i_clock,
  input  logic        i_resetN,
  input  logic [31:0] i_fifoData,
  input  logic        i_fifoEmpty,
  output logic        o_fifoRead,
  input  logic        i_frameStart,
  output logic [23:0] o_pixelData,
  output logic        o_pixelValid,
  input  logic        i_pixelReady,
  output logic        o_lineEnd,
  output logic        o_frameEnd
);

  localparam int COL_W = $clog2(H_ACTIVE);
  localparam int ROW_W = $clog2(V_ACTIVE);

  logic [1:0]       r_phase;
  logic [23:0]      r_res;
  logic [23:0]      resNext;
  logic [23:0]      pixelNext;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             free;
  logic             advance;
  logic             colLast;
  logic             rowLast;

  assign free       = ~o_pixelValid | i_pixelReady;
  assign advance    = free & ((r_phase == 2'd3) | ~i_fifoEmpty) & ~i_frameStart;
  // Phase 3 drains the residue only, so it never pops the FIFO.
  assign o_fifoRead = advance & (r_phase != 2'd3) & i_resetN;
  assign colLast    = (r_col == COL_W'(H_ACTIVE - 1));
  assign rowLast    = (r_row == ROW_W'(V_ACTIVE - 1));

  always_comb begin
    pixelNext = r_res;
    resNext   = r_res;
    case (r_phase)
      2'd0: begin
        pixelNext = i_fifoData[31:8];
        resNext   = {r_res[23:8], i_fifoData[7:0]};
      end
      2'd1: begin
        pixelNext = {r_res[7:0], i_fifoData[31:16]};
        resNext   = {r_res[23:16], i_fifoData[15:0]};
      end
      2'd2: begin
        pixelNext = {r_res[15:0], i_fifoData[31:24]};
        resNext   = i_fifoData[23:0];
      end
      default: begin
        pixelNext = r_res;
        resNext   = r_res;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_phase      <= 2'd0;
      r_res        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      o_pixelData  <= '0;
      o_pixelValid <= 1'b0;
      o_lineEnd    <= 1'b0;
      o_frameEnd   <= 1'b0;
    end else if (i_frameStart) begin
      // Resync wins over everything; pending pixel and residue are dropped.
      r_phase      <= 2'd0;
      r_res        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      o_pixelValid <= 1'b0;
      o_lineEnd    <= 1'b0;
      o_frameEnd   <= 1'b0;
    end else if (advance) begin
      r_phase      <= r_phase + 2'd1;
      r_res        <= resNext;
      o_pixelData  <= pixelNext;
      o_pixelValid <= 1'b1;
      o_lineEnd    <= colLast;
      o_frameEnd   <= colLast & rowLast;
      if (colLast) begin
        r_col <= '0;
        r_row <= rowLast ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end else if (free) begin
      o_pixelValid <= 1'b0;
    end
  end

endmodule

// File: doc/fifo_pixel_unpacker.md
# fifo_pixel_unpacker

Reads 32-bit packed pixel words from the frame FIFO and unpacks them into a 24-bit RGB pixel stream (R in [23:16], G in [15:8], B in [7:0]) for the LCD drive path. Every 3 FIFO words yield 4 pixels. Packing is MSB-first: the first pixel occupies word bits [31:8]. The block also tracks pixel position so it can flag end-of-line and end-of-frame, and it resynchronises its packing phase on a frame-start pulse.

## Interface
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 480, active lines per frame
- i_clock  in  1  single clock for all logic
- i_resetN  in  1  reset; asynchronous, active-low
- i_fifoData  in  32  FIFO head word; show-ahead, valid whenever i_fifoEmpty=0
- i_fifoEmpty  in  1  FIFO empty flag
- o_fifoRead  out  1  pop FIFO head this cycle; combinational
- i_frameStart  in  1  one-cycle pulse; resets packing phase and position counters
- o_pixelData  out  24  current pixel, RGB
- o_pixelValid  out  1  o_pixelData holds a valid pixel
- i_pixelReady  in  1  consumer accepts the pixel when o_pixelValid=1 and i_pixelReady=1
- o_lineEnd  out  1  current pixel is the last pixel of a line; meaningful only with o_pixelValid
- o_frameEnd  out  1  current pixel is the last pixel of a frame; meaningful only with o_pixelValid

## Operation
- Phase register r_phase (2 bits, 0..3) and residue register r_res (24 bits).
- Output slot is free when o_pixelValid=0 or i_pixelReady=1. Call this `free`.
- advance = free & (r_phase==3 | !i_fifoEmpty) & !i_frameStart.
- o_fifoRead = advance & (r_phase!=3) & i_resetN.
- On advance, with W = i_fifoData:
  - phase 0: pixel = W[31:8]; r_res[7:0] <= W[7:0]
  - phase 1: pixel = {r_res[7:0], W[31:16]}; r_res[15:0] <= W[15:0]
  - phase 2: pixel = {r_res[15:0], W[31:24]}; r_res[23:0] <= W[23:0]
  - phase 3: pixel = r_res[23:0]; no FIFO pop
  - In every case, r_phase <= r_phase+1 (wraps 3->0), o_pixelData <= pixel, o_pixelValid <= 1.
- When free=1 and advance=0 (starved), o_pixelValid <= 0.
- When free=0 (stall), all registers hold; o_pixelData is stable while o_pixelValid=1 and i_pixelReady=0.
- Position counters r_col (0..H_ACTIVE-1) and r_row (0..V_ACTIVE-1) update on advance:
  - o_lineEnd <= (r_col==H_ACTIVE-1)
  - o_frameEnd <= (r_col==H_ACTIVE-1) & (r_row==V_ACTIVE-1)
  - r_col wraps to 0 at H_ACTIVE-1 and then increments r_row.
  - r_row wraps to 0 at V_ACTIVE-1.
- i_frameStart has priority over everything. At the next edge it sets r_phase=0, r_res=0, r_col=0, r_row=0, o_pixelValid=0, o_lineEnd=0, o_frameEnd=0. Any undelivered pixel or residue is discarded, and no pop occurs in that cycle.
- A frame is exactly H_ACTIVE*V_ACTIVE pixels. Because 800*480 is a multiple of 4, phase returns to 0 at the frame boundary without a frameStart.

## Timing
- Reset (i_resetN=0) sets: o_pixelData=0, o_pixelValid=0, o_lineEnd=0, o_frameEnd=0, r_phase=0, r_res=0, r_col=0, r_row=0, o_fifoRead=0.
- Release of reset is synchronous to the first rising edge after i_resetN rises.
- Latency: a word present at the FIFO head with a free slot gives its pixel on o_pixelData after the next rising edge (1 cycle).
- Throughput: 1 pixel/clock sustained while the FIFO is non-empty and i_pixelReady=1. This equals 3 pops per 4 clocks, with o_fifoRead=0 in the phase-3 cycle.
- FIFO empty in phases 0-2: no pop, no phase change; o_pixelValid drops once the current pixel is accepted.
- Phase 3 with the FIFO empty still emits the residue pixel.
- Simultaneous i_frameStart and i_pixelReady: the pixel counts as delivered, then the block is cleared.
- Simultaneous i_frameStart and a FIFO word: the word is not popped.

## Test plan
- Reset with FIFO non-empty -> o_fifoRead=0 and all outputs 0 while i_resetN=0. First pop occurs on the edge after release.
- Words 0x11223344, 0x55667788, 0x99AABBCC with i_pixelReady=1 -> pixels 0x112233, 0x445566, 0x778899, 0xAABBCC on 4 consecutive clocks. o_fifoRead pattern is 1,1,1,0.
- Same stream with i_pixelReady=0 for 5 cycles after the second pixel -> o_pixelData holds 0x445566, no pops occur, and the sequence resumes intact.
- FIFO empties after word 0x11223344 -> one pixel 0x112233, then o_pixelValid=0. Pushing 0x55667788 then yields 0x445566.
- i_frameStart pulse at phase 2 -> next pixel is taken from the new FIFO head's [31:8], and r_col restarts at 0.
- Full 800x480 frame of incrementing data -> o_lineEnd on every 800th pixel (480 times), and o_frameEnd only on pixel 384000.
